// File: rtl/seq_1011_det.sv
// -----------------------------------------------------------------------------
// seq_1011_det
//   Serial bit-pattern detector. Samples din on every rising clk edge and
//   pulses y for one cycle each time the pattern PATTERN (first-received bit
//   is PATTERN[PAT_LEN-1]) has just been completed. Moore FSM with a
//   registered output.
//
//   The state is "number of pattern bits matched so far", 0..PAT_LEN, with
//   PAT_LEN being the match state.
//
// Parameters
//   PAT_LEN  pattern length in bits, legal range 2..16
//   PATTERN  pattern bits, MSB received first
//   OVERLAP  1: the tail of a match may begin the next match
//            0: restart from scratch after a match
//
// Ports
//   clk    in  1  rising-edge clock
//   reset  in  1  asynchronous, active-high reset
//   din    in  1  serial data bit
//   y      out 1  registered match pulse
// -----------------------------------------------------------------------------
module seq_1011_det #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter bit                 OVERLAP = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic y
);

    localparam int SW = $clog2(PAT_LEN + 1);
    // Every encoding the state register can hold gets a table entry, so
    // unused encodings can be steered back to S0 without a range check.
    localparam int NS = 2 ** SW;

    typedef logic [SW-1:0] state_t;

    localparam state_t S0      = '0;
    localparam state_t S_MATCH = state_t'(PAT_LEN);

    // Next state from state s on input bit b. The bits seen so far are the
    // first s pattern bits followed by b; the result is the longest pattern
    // prefix that is a suffix of that string (KMP failure rule). Evaluated
    // only at elaboration to build constant transition tables.
    function automatic int next_of(input int s, input int b);
        logic [PAT_LEN:0] w;     // w[i] = i-th bit received
        int               base;
        int               len;
        int               res;
        bit               ok;
        base = s;
        if (s >= PAT_LEN && !OVERLAP) begin
            base = 0;            // after a match, behave as if idle
        end
        w   = '0;
        res = 0;
        for (int i = 0; i < base; i++) begin
            w[i] = PATTERN[PAT_LEN-1-i];
        end
        w[base] = b[0];
        len     = base + 1;
        for (int k = (len < PAT_LEN) ? len : PAT_LEN; k >= 1; k--) begin
            ok = 1'b1;
            for (int i = 0; i < k; i++) begin
                if (w[len-k+i] != PATTERN[PAT_LEN-1-i]) begin
                    ok = 1'b0;
                end
            end
            if (ok && res == 0) begin
                res = k;         // descending k: first hit is the longest
            end
        end
        return res;
    endfunction

    state_t tbl0 [NS];   // next state when din = 0
    state_t tbl1 [NS];   // next state when din = 1

    genvar gi;
    generate
        for (gi = 0; gi < NS; gi++) begin : g_tbl
            if (gi <= PAT_LEN) begin : g_valid
                assign tbl0[gi] = state_t'(next_of(gi, 0));
                assign tbl1[gi] = state_t'(next_of(gi, 1));
            end else begin : g_invalid
                assign tbl0[gi] = S0;
                assign tbl1[gi] = S0;
            end
        end
    endgenerate

    state_t state_reg;
    state_t state_next;
    logic   y_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S0;
            y_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            // Registered decode of the match state: y tracks state_reg
            // exactly and never sees din combinationally.
            y_reg     <= (state_next == S_MATCH);
        end
    end

    always_comb begin
        state_next = S0;
        case (din)
            1'b0:    state_next = tbl0[state_reg];
            1'b1:    state_next = tbl1[state_reg];
            default: state_next = S0;   // unknown input counts as a mismatch
        endcase
    end

    assign y = y_reg;

endmodule

// File: tb/tb_seq_1011_det.sv
// -----------------------------------------------------------------------------
// tb_seq_1011_det
//   Self-checking bench for seq_1011_det. Two instances share the stimulus:
//   one with overlapping matches, one without. The reference keeps the recent
//   history of received bits and declares a match whenever that history ends
//   in 1011; the non-overlapping reference forgets its history after a match.
//   din is driven and y is checked on falling clock edges.
// -----------------------------------------------------------------------------
module tb_seq_1011_det;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic din   = 1'b0;
    logic y;
    logic y_no;

    int total = 0;
    int bad   = 0;

    localparam bit [3:0] PAT = 4'b1011;

    bit hist_ov [$];
    bit hist_no [$];

    seq_1011_det #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1)) u_dut (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .y     (y)
    );

    seq_1011_det #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0)) u_dut_no (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .y     (y_no)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit ends_with_pat(input bit q [$]);
        bit hit;
        if (q.size() < 4) return 1'b0;
        hit = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (q[q.size()-4+i] != PAT[3-i]) hit = 1'b0;
        end
        return hit;
    endfunction

    task automatic clear_models();
        hist_ov.delete();
        hist_no.delete();
    endtask

    // Drive one bit at a falling edge, let it be sampled, check at the next
    // falling edge.
    task automatic send_bit(input bit b, input string tag);
        bit e_ov;
        bit e_no;
        din = b;
        @(posedge clk);
        @(negedge clk);
        hist_ov.push_back(b);
        hist_no.push_back(b);
        if (hist_ov.size() > 4) void'(hist_ov.pop_front());
        if (hist_no.size() > 4) void'(hist_no.pop_front());
        e_ov = ends_with_pat(hist_ov);
        e_no = ends_with_pat(hist_no);
        if (e_no) hist_no.delete();
        $display("%s din=%0d y=%b/%b y_no=%b/%b", tag, b, y, e_ov, y_no, e_no);
        chk({tag, ".ov"}, y, e_ov);
        chk({tag, ".no"}, y_no, e_no);
    endtask

    task automatic send_seq(input bit [15:0] bits, input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) send_bit(bits[i], tag);
    endtask

    // Reset pulse placed between edges; outputs must drop at once.
    task automatic pulse_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        $display("%s async reset y=%b y_no=%b", tag, y, y_no);
        chk({tag, ".rst_ov"}, y, 1'b0);
        chk({tag, ".rst_no"}, y_no, 1'b0);
        #1 reset = 1'b0;
        clear_models();
    endtask

    initial begin
        // 1. reset held for two cycles with din toggling
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            din = ~din;
            @(negedge clk);
            $display("reset cycle %0d y=%b y_no=%b", i, y, y_no);
            chk("reset.ov", y, 1'b0);
            chk("reset.no", y_no, 1'b0);
        end
        reset = 1'b0;
        clear_models();

        // 2. basic match
        send_seq(16'b1011, 4, "basic");
        send_bit(1'b0, "flush");
        send_bit(1'b0, "flush");

        // 3. overlap
        send_seq(16'b1011011, 7, "overlap");
        send_seq(16'b000, 3, "flush");

        // 4. near misses
        send_seq(16'b11011, 5, "nearmiss_a");
        send_seq(16'b000, 3, "flush");
        send_seq(16'b1001011, 7, "nearmiss_b");
        send_seq(16'b000, 3, "flush");

        // 5. steady input
        send_seq(16'hFF, 8, "steady1");
        send_seq(16'b000, 3, "flush");
        send_seq(16'b101111111, 9, "match_then_ones");

        // 6. async reset mid-sequence, then reset while y is high
        send_seq(16'b000, 3, "flush");
        send_seq(16'b101, 3, "midseq");
        pulse_reset("midseq");
        send_bit(1'b1, "midseq_after");
        send_seq(16'b000, 3, "flush");
        send_seq(16'b1011, 4, "pulse");
        chk("pulse.pre_ov", y, 1'b1);
        pulse_reset("pulse");
        send_bit(1'b1, "pulse_after");

        // randomized stream, weighted toward 1s so matches occur often
        for (int i = 0; i < 300; i++) begin
            send_bit(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0, "rand");
            if ($urandom_range(0, 99) == 0) pulse_reset("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
